// File: rtl/gpu_pkg.sv
// gpu_pkg: shared dispatcher state encoding, voxel record layout and datapath widths
package gpu_pkg;
    localparam int COORD_BITS   = 8;
    localparam int PALETTE_BITS = 8;
    localparam int PIXEL_BITS   = 8;

    typedef enum logic [3:0] {
        IDLE, FETCH, WAIT_VOX, RASTER, WAIT_RASTER, SHADE, WAIT_SHADE, READOUT, DONE
    } dispatch_state_t;

    // Same bit layout as the voxel memory word: x in the LSBs, id in the MSBs.
    typedef struct packed {
        logic [PALETTE_BITS-1:0] id;
        logic [COORD_BITS-1:0]   z;
        logic [COORD_BITS-1:0]   y;
        logic [COORD_BITS-1:0]   x;
    } voxel_t;
endpackage

// File: rtl/readout_scanner.sv
// readout_scanner: row-major row/col walker over a NUM_ROWS x NUM_COLS grid
// Ports: clock/reset (async, active high); clear zeroes the position; advance steps
// one cell (wrapping to 0/0 after the final cell); row/col give the current cell;
// last flags the final cell.
module readout_scanner #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4,
    parameter int ROW_BITS = 8,
    parameter int COL_BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                advance,
    output logic [ROW_BITS-1:0] row,
    output logic [COL_BITS-1:0] col,
    output logic                last
);
    logic last_col;

    assign last_col = col == COL_BITS'(NUM_COLS - 1);
    assign last     = last_col && row == ROW_BITS'(NUM_ROWS - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear || (advance && last)) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            row <= last_col ? row + ROW_BITS'(1) : row;
            col <= last_col ? '0 : col + COL_BITS'(1);
        end
    end
endmodule

// File: rtl/shader_dispatcher.sv
// shader_dispatcher: frame initiator that feeds voxels to the shader array, triggers shading and streams pixels out
// Ports: clock/reset (async, active high); start/num_voxels begin a frame; busy/frame_done
// report progress; vox_rd/vox_addr/vox_rvalid/vox_rdata read voxel memory; do_rasterize,
// do_shade and voxel_* broadcast to the shaders, which answer on rasterizing_done and
// shading_done; row/col select a shader on the pixel bus; fb_* is the framebuffer stream.
module shader_dispatcher
    import gpu_pkg::dispatch_state_t;
#(
    parameter int NUM_ROWS      = 4,
    parameter int NUM_COLS      = 4,
    parameter int ROW_BITS      = 8,
    parameter int COL_BITS      = 8,
    parameter int COORD_BITS    = 8,
    parameter int PALETTE_BITS  = 8,
    parameter int PIXEL_BITS    = 8,
    parameter int VOX_ADDR_BITS = 10
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [VOX_ADDR_BITS-1:0]           num_voxels,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               vox_rd,
    output logic [VOX_ADDR_BITS-1:0]           vox_addr,
    input  logic                               vox_rvalid,
    input  logic [3*COORD_BITS+PALETTE_BITS-1:0] vox_rdata,
    output logic                               do_rasterize,
    output logic                               do_shade,
    output logic [COORD_BITS-1:0]              voxel_x,
    output logic [COORD_BITS-1:0]              voxel_y,
    output logic [COORD_BITS-1:0]              voxel_z,
    output logic [PALETTE_BITS-1:0]            voxel_id,
    input  logic                               rasterizing_done,
    input  logic                               shading_done,
    output logic [ROW_BITS-1:0]                row,
    output logic [COL_BITS-1:0]                col,
    input  logic [PIXEL_BITS-1:0]              pixel,
    output logic                               fb_valid,
    input  logic                               fb_ready,
    output logic [ROW_BITS+COL_BITS-1:0]       fb_addr,
    output logic [PIXEL_BITS-1:0]              fb_data
);
    dispatch_state_t state, next;
    logic [VOX_ADDR_BITS-1:0] index, count;
    logic guard, last_vox, last_pix;

    // The shaders' done lines still reflect the previous job for one cycle after a strobe,
    // so the first cycle of each wait state ignores them.
    assign last_vox = index == count - VOX_ADDR_BITS'(1);

    readout_scanner #(
        .NUM_ROWS(NUM_ROWS),
        .NUM_COLS(NUM_COLS),
        .ROW_BITS(ROW_BITS),
        .COL_BITS(COL_BITS)
    ) u_scan (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == gpu_pkg::IDLE),
        .advance(state == gpu_pkg::READOUT && fb_ready),
        .row    (row),
        .col    (col),
        .last   (last_pix)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= gpu_pkg::IDLE;
        else       state <= next;
    end

    always_comb begin
        next         = state;
        busy         = state != gpu_pkg::IDLE;
        frame_done   = state == gpu_pkg::DONE;
        vox_rd       = state == gpu_pkg::FETCH;
        vox_addr     = index;
        do_rasterize = state == gpu_pkg::RASTER;
        do_shade     = state == gpu_pkg::SHADE;
        fb_valid     = state == gpu_pkg::READOUT;
        fb_addr      = {row, col};
        fb_data      = state == gpu_pkg::READOUT ? pixel : '0;
        case (state)
            gpu_pkg::IDLE:        if (start) next = num_voxels == '0 ? gpu_pkg::SHADE : gpu_pkg::FETCH;
            gpu_pkg::FETCH:       next = gpu_pkg::WAIT_VOX;
            gpu_pkg::WAIT_VOX:    if (vox_rvalid) next = gpu_pkg::RASTER;
            gpu_pkg::RASTER:      next = gpu_pkg::WAIT_RASTER;
            gpu_pkg::WAIT_RASTER: if (!guard && rasterizing_done) next = last_vox ? gpu_pkg::SHADE : gpu_pkg::FETCH;
            gpu_pkg::SHADE:       next = gpu_pkg::WAIT_SHADE;
            gpu_pkg::WAIT_SHADE:  if (!guard && shading_done) next = gpu_pkg::READOUT;
            gpu_pkg::READOUT:     if (fb_ready && last_pix) next = gpu_pkg::DONE;
            default:              next = gpu_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            guard    <= 1'b0;
            index    <= '0;
            count    <= '0;
            voxel_x  <= '0;
            voxel_y  <= '0;
            voxel_z  <= '0;
            voxel_id <= '0;
        end else begin
            guard <= state == gpu_pkg::RASTER || state == gpu_pkg::SHADE;
            if (state == gpu_pkg::IDLE && start) begin
                count <= num_voxels;
                index <= '0;
            end
            if (state == gpu_pkg::WAIT_VOX && vox_rvalid) begin
                voxel_x  <= vox_rdata[COORD_BITS-1:0];
                voxel_y  <= vox_rdata[2*COORD_BITS-1:COORD_BITS];
                voxel_z  <= vox_rdata[3*COORD_BITS-1:2*COORD_BITS];
                voxel_id <= vox_rdata[3*COORD_BITS+PALETTE_BITS-1:3*COORD_BITS];
            end
            if (state == gpu_pkg::WAIT_RASTER && !guard && rasterizing_done && !last_vox)
                index <= index + VOX_ADDR_BITS'(1);
        end
    end
endmodule

// File: tb/tb_shader_dispatcher.sv
// tb_shader_dispatcher: directed scenarios for shader_dispatcher on a 2x3 shader array
module tb_shader_dispatcher;
    import gpu_pkg::*;

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [9:0]  num_voxels = '0;
    logic        busy, frame_done, vox_rd, vox_rvalid = 1'b0;
    logic [9:0]  vox_addr;
    logic [31:0] vox_rdata = '0;
    logic        do_rasterize, do_shade, rasterizing_done = 1'b0, shading_done = 1'b0;
    logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id, row, col, pixel, fb_data;
    logic        fb_valid, fb_ready = 1'b1;
    logic [15:0] fb_addr;

    int errors = 0, checks = 0, cyc = 0;
    voxel_t mem [4];
    logic [7:0] salt = 8'h00;
    int rdelay = 1, sdelay = 1, raster_wait = -1, shade_wait = -1;
    bit raster_hold = 0, rd_pend = 0;
    logic [9:0] rd_pend_addr = '0;
    logic [15:0] bp_addr = '0;
    int bp_left = 0, stalls = 0, hold_bad = 0;
    int n_rd, n_ras, n_shade, n_done, shade_cyc, start_cyc, done_cyc;
    int rd_addr [$], rd_cyc [$], ras_cyc [$];
    logic [15:0] beat_addr [$];
    logic [7:0]  beat_data [$];

    // Shader array model: each shader drives a distinct value derived from its position.
    assign pixel = {row[3:0], col[3:0]} ^ salt;

    shader_dispatcher #(.NUM_ROWS(2), .NUM_COLS(3)) dut (
        .clock(clock), .reset(reset), .start(start), .num_voxels(num_voxels),
        .busy(busy), .frame_done(frame_done), .vox_rd(vox_rd), .vox_addr(vox_addr),
        .vox_rvalid(vox_rvalid), .vox_rdata(vox_rdata), .do_rasterize(do_rasterize),
        .do_shade(do_shade), .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z),
        .voxel_id(voxel_id), .rasterizing_done(rasterizing_done), .shading_done(shading_done),
        .row(row), .col(col), .pixel(pixel), .fb_valid(fb_valid), .fb_ready(fb_ready),
        .fb_addr(fb_addr), .fb_data(fb_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic logic [7:0] pix(logic [15:0] a);
        return {a[11:8], a[3:0]} ^ salt;
    endfunction

    // Observation plus framebuffer backpressure, all on the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (fb_valid && fb_addr == bp_addr && bp_left > 0) begin
                fb_ready = 1'b0;
                bp_left--;
                stalls++;
            end else fb_ready = 1'b1;
            if (fb_valid && !fb_ready && (fb_addr !== bp_addr || fb_data !== pix(bp_addr))) hold_bad++;
            if (fb_valid && fb_ready) begin
                beat_addr.push_back(fb_addr);
                beat_data.push_back(fb_data);
            end
            if (vox_rd) begin
                n_rd++;
                rd_addr.push_back(int'(vox_addr));
                rd_cyc.push_back(cyc);
                rd_pend = 1;
                rd_pend_addr = vox_addr;
            end
            if (do_rasterize) begin
                n_ras++;
                ras_cyc.push_back(cyc);
                raster_wait = rdelay;
            end
            if (do_shade) begin
                n_shade++;
                shade_cyc = cyc;
                shade_wait = sdelay;
            end
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // Voxel memory (one-cycle read latency) and shader done responders.
    always @(posedge clock) begin
        #1;
        vox_rvalid = rd_pend;
        vox_rdata  = rd_pend ? mem[rd_pend_addr[1:0]] : 32'hDEAD_BEEF;
        rd_pend    = 0;
        if (raster_hold) rasterizing_done = 1'b1;
        else if (raster_wait == 0) begin
            rasterizing_done = 1'b1;
            raster_wait = -1;
        end else begin
            rasterizing_done = 1'b0;
            if (raster_wait > 0) raster_wait--;
        end
        if (shade_wait == 0) begin
            shading_done = 1'b1;
            shade_wait = -1;
        end else begin
            shading_done = 1'b0;
            if (shade_wait > 0) shade_wait--;
        end
    end

    task automatic clear_log();
        n_rd = 0; n_ras = 0; n_shade = 0; n_done = 0;
        shade_cyc = -1; done_cyc = -1; stalls = 0; hold_bad = 0; bp_left = 0;
        rd_addr.delete(); rd_cyc.delete(); ras_cyc.delete();
        beat_addr.delete(); beat_data.delete();
    endtask

    task automatic pulse_start(input logic [9:0] n);
        @(negedge clock);
        num_voxels = n;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && n_done == 0; i++) @(posedge clock);
        checks++;
        if (n_done == 0) begin
            errors++;
            $display("FAIL frame_timeout: frame_done not seen within 400 cycles");
        end
        @(negedge clock);
    endtask

    task automatic check_beats(input string tag);
        checks++;
        if (beat_addr.size() !== 6) begin
            errors++;
            $display("FAIL %s_beat_count: got %0d want 6", tag, beat_addr.size());
        end
        for (int i = 0; i < 6 && i < beat_addr.size(); i++) begin
            logic [15:0] ea;
            ea = {8'(i / 3), 8'(i % 3)};
            checks++;
            if (beat_addr[i] !== ea || beat_data[i] !== pix(ea)) begin
                errors++;
                $display("FAIL %s_beat%0d: got addr %h data %h want addr %h data %h",
                         tag, i, beat_addr[i], beat_data[i], ea, pix(ea));
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        logic [95:0] got;
        got = {busy, frame_done, vox_rd, vox_addr, do_rasterize, do_shade, voxel_x, voxel_y,
               voxel_z, voxel_id, row, col, fb_valid, fb_addr, fb_data};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s_outputs_zero: got %h want 0", tag, got);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single_voxel();
        mem[0] = '{id: 8'd5, z: 8'd3, y: 8'd2, x: 8'd1};
        clear_log();
        rdelay = 1; sdelay = 1;
        pulse_start(10'd1);
        wait_done();
        checks++;
        if (n_rd !== 1 || rd_addr.size() == 0 || rd_addr[0] !== 0) begin
            errors++;
            $display("FAIL single_vox_rd: got %0d reads want 1 read at addr 0", n_rd);
        end
        checks++;
        if ({voxel_id, voxel_z, voxel_y, voxel_x} !== 32'h05030201) begin
            errors++;
            $display("FAIL single_voxel_regs: got %h want 05030201", {voxel_id, voxel_z, voxel_y, voxel_x});
        end
        checks++;
        if (n_ras !== 1 || n_shade !== 1 || n_done !== 1) begin
            errors++;
            $display("FAIL single_strobes: got ras %0d shade %0d done %0d want 1 1 1", n_ras, n_shade, n_done);
        end
        checks++;
        if (done_cyc - start_cyc !== 15) begin
            errors++;
            $display("FAIL single_latency: got %0d want 15", done_cyc - start_cyc);
        end
        check_beats("single");
    endtask

    task automatic test_multi_voxel();
        mem[0] = '{id: 8'h11, z: 8'h12, y: 8'h13, x: 8'h14};
        mem[1] = '{id: 8'h21, z: 8'h22, y: 8'h23, x: 8'h24};
        mem[2] = '{id: 8'h31, z: 8'h32, y: 8'h33, x: 8'h34};
        clear_log();
        rdelay = 4; salt = 8'h3C;
        pulse_start(10'd3);
        wait_done();
        checks++;
        if (rd_addr.size() !== 3 || rd_addr[0] !== 0 || rd_addr[1] !== 1 || rd_addr[2] !== 2) begin
            errors++;
            $display("FAIL multi_addr_seq: got %0d reads want addrs 0,1,2", rd_addr.size());
        end
        checks++;
        if (n_ras !== 3) begin
            errors++;
            $display("FAIL multi_raster_count: got %0d want 3", n_ras);
        end
        checks++;
        if (ras_cyc.size() != 3 || shade_cyc - ras_cyc[2] !== 6) begin
            errors++;
            $display("FAIL multi_shade_after_done: got gap %0d want 6", shade_cyc - (ras_cyc.size() > 0 ? ras_cyc[ras_cyc.size() - 1] : 0));
        end
        checks++;
        if ({voxel_id, voxel_z, voxel_y, voxel_x} !== 32'h31323334) begin
            errors++;
            $display("FAIL multi_voxel_regs: got %h want 31323334", {voxel_id, voxel_z, voxel_y, voxel_x});
        end
        check_beats("multi");
        rdelay = 1;
    endtask

    task automatic test_zero_voxels();
        clear_log();
        salt = 8'h5A;
        pulse_start(10'd0);
        wait_done();
        checks++;
        if (n_rd !== 0 || n_ras !== 0) begin
            errors++;
            $display("FAIL zero_no_fetch: got rd %0d ras %0d want 0 0", n_rd, n_ras);
        end
        checks++;
        if (shade_cyc - start_cyc !== 1) begin
            errors++;
            $display("FAIL zero_shade_delay: got %0d want 1", shade_cyc - start_cyc);
        end
        check_beats("zero");
    endtask

    task automatic test_backpressure();
        clear_log();
        salt = 8'hA5;
        bp_addr = 16'h0001;
        bp_left = 3;
        pulse_start(10'd1);
        wait_done();
        checks++;
        if (stalls !== 3 || hold_bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: got stalls %0d bad holds %0d want 3 0", stalls, hold_bad);
        end
        check_beats("bp");
    endtask

    task automatic test_raster_held();
        clear_log();
        salt = 8'h00;
        raster_hold = 1;
        pulse_start(10'd2);
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clock);
        checks++;
        if (n_rd !== 2 || n_ras !== 2) begin
            errors++;
            $display("FAIL held_counts: got rd %0d ras %0d want 2 2", n_rd, n_ras);
        end
        checks++;
        if (rd_cyc.size() < 2 || ras_cyc.size() < 1 || rd_cyc[1] - ras_cyc[0] !== 3) begin
            errors++;
            $display("FAIL held_guard_gap: got %0d want 3", (rd_cyc.size() > 1 && ras_cyc.size() > 0) ? rd_cyc[1] - ras_cyc[0] : -1);
        end
        checks++;
        if (n_done !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_start_ignored: got done %0d busy %b want 1 0", n_done, busy);
        end
        raster_hold = 0;
    endtask

    task automatic test_reset_readout();
        bit seen = 0;
        clear_log();
        pulse_start(10'd1);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            seen = fb_valid && fb_addr == 16'h0100;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_reach_beat: got no beat at 0100 want one");
        end
        #1 reset = 1'b1;
        #1 check_idle_outputs("midreset");
        raster_wait = -1; shade_wait = -1; rd_pend = 0;
        @(negedge clock);
        reset = 1'b0;
        clear_log();
        pulse_start(10'd1);
        wait_done();
        check_beats("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_voxel();
        test_multi_voxel();
        test_zero_voxels();
        test_backpressure();
        test_raster_held();
        test_reset_readout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
